// File: rtl/calc2_req_port_if.sv
// rtl/calc2_req_port_if.sv - Host, calc2 request/response and status signal bundle for calc2_req_port
interface calc2_req_port_if;
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  host_cmd;
    logic [31:0] host_op1;
    logic [31:0] host_op2;
    logic [1:0]  host_tag;

    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;

    logic [1:0]  rsp_resp_in;
    logic [31:0] rsp_data_in;
    logic [1:0]  rsp_tag_in;

    logic        cpl_valid;
    logic [1:0]  cpl_tag;
    logic [1:0]  cpl_resp;
    logic [31:0] cpl_data;
    logic        to_valid;
    logic [1:0]  to_tag;
    logic        err_stray;
    logic [2:0]  outstanding;

    modport master (
        output host_valid, host_cmd, host_op1, host_op2,
        output rsp_resp_in, rsp_data_in, rsp_tag_in,
        input  host_ready, host_tag,
        input  req_cmd_out, req_data_out, req_tag_out,
        input  cpl_valid, cpl_tag, cpl_resp, cpl_data,
        input  to_valid, to_tag, err_stray, outstanding
    );

    modport slave (
        input  host_valid, host_cmd, host_op1, host_op2,
        input  rsp_resp_in, rsp_data_in, rsp_tag_in,
        output host_ready, host_tag,
        output req_cmd_out, req_data_out, req_tag_out,
        output cpl_valid, cpl_tag, cpl_resp, cpl_data,
        output to_valid, to_tag, err_stray, outstanding
    );
endinterface

// File: rtl/calc2_req_port.sv
// rtl/calc2_req_port.sv - Per-port calc2 requester: tag allocation, two-cycle issue, response matching, timeouts
module calc2_req_port #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic             c_clk,
    input logic             reset,
    calc2_req_port_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_OP2  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] AGE_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] AGE_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] AGE_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       busy_q, busy_d;
    logic [CNT_W-1:0] age_q [4];
    logic [CNT_W-1:0] age_d [4];
    logic [31:0]      op2_q, op2_d;
    logic [3:0]       req_cmd_q, req_cmd_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [1:0]       req_tag_q, req_tag_d;
    logic             cpl_valid_q, cpl_valid_d;
    logic [1:0]       cpl_tag_q, cpl_tag_d;
    logic [1:0]       cpl_resp_q, cpl_resp_d;
    logic [31:0]      cpl_data_q, cpl_data_d;
    logic             to_valid_q, to_valid_d;
    logic [1:0]       to_tag_q, to_tag_d;
    logic             err_stray_q, err_stray_d;
    logic [2:0]       outstanding_q, outstanding_d;

    logic       host_ready;
    logic       issue;
    logic       rsp_hit;
    logic       rsp_match;
    logic [1:0] alloc_tag;
    logic       to_hit;
    logic [1:0] to_sel;

    assign host_ready = !reset && (state_q != ST_CMD) && (busy_q != 4'hF);
    assign issue      = bus.host_valid && host_ready && (bus.host_cmd != 4'd0);
    assign rsp_hit    = bus.rsp_resp_in != 2'd0;
    assign rsp_match  = rsp_hit && busy_q[bus.rsp_tag_in];

    always_comb begin
        alloc_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy_q[i]) alloc_tag = 2'(i);
        end
    end

    // A tag answered this cycle is completed, never timed out.
    always_comb begin
        to_hit = 1'b0;
        to_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (busy_q[i] && (age_q[i] >= AGE_LIM) && !(rsp_match && (bus.rsp_tag_in == 2'(i)))) begin
                to_hit = 1'b1;
                to_sel = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        age_d       = age_q;
        op2_d       = op2_q;
        req_cmd_d   = 4'd0;
        req_data_d  = 32'd0;
        req_tag_d   = 2'd0;
        cpl_valid_d = 1'b0;
        cpl_tag_d   = cpl_tag_q;
        cpl_resp_d  = cpl_resp_q;
        cpl_data_d  = cpl_data_q;
        to_valid_d  = 1'b0;
        to_tag_d    = to_tag_q;
        err_stray_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OP2: begin
                state_d = ST_IDLE;
                if (issue) begin
                    state_d    = ST_CMD;
                    op2_d      = bus.host_op2;
                    req_cmd_d  = bus.host_cmd;
                    req_data_d = bus.host_op1;
                    req_tag_d  = alloc_tag;
                end
            end
            ST_CMD: begin
                state_d    = ST_OP2;
                req_data_d = op2_q;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < 4; i++) begin
            if (busy_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + AGE_ONE;
        end

        if (rsp_hit) begin
            if (rsp_match) begin
                cpl_valid_d              = 1'b1;
                cpl_tag_d                = bus.rsp_tag_in;
                cpl_resp_d               = bus.rsp_resp_in;
                cpl_data_d               = bus.rsp_data_in;
                busy_d[bus.rsp_tag_in]   = 1'b0;
                age_d[bus.rsp_tag_in]    = '0;
            end else begin
                err_stray_d = 1'b1;
            end
        end

        if (to_hit) begin
            to_valid_d     = 1'b1;
            to_tag_d       = to_sel;
            busy_d[to_sel] = 1'b0;
            age_d[to_sel]  = '0;
        end

        // The allocation edge itself counts as the first cycle of age.
        if (issue) begin
            busy_d[alloc_tag] = 1'b1;
            age_d[alloc_tag]  = AGE_ONE;
        end

        outstanding_d = 3'(busy_d[0]) + 3'(busy_d[1]) + 3'(busy_d[2]) + 3'(busy_d[3]);
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 4'd0;
            age_q         <= '{default: '0};
            op2_q         <= 32'd0;
            req_cmd_q     <= 4'd0;
            req_data_q    <= 32'd0;
            req_tag_q     <= 2'd0;
            cpl_valid_q   <= 1'b0;
            cpl_tag_q     <= 2'd0;
            cpl_resp_q    <= 2'd0;
            cpl_data_q    <= 32'd0;
            to_valid_q    <= 1'b0;
            to_tag_q      <= 2'd0;
            err_stray_q   <= 1'b0;
            outstanding_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            age_q         <= age_d;
            op2_q         <= op2_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            req_tag_q     <= req_tag_d;
            cpl_valid_q   <= cpl_valid_d;
            cpl_tag_q     <= cpl_tag_d;
            cpl_resp_q    <= cpl_resp_d;
            cpl_data_q    <= cpl_data_d;
            to_valid_q    <= to_valid_d;
            to_tag_q      <= to_tag_d;
            err_stray_q   <= err_stray_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.host_ready   = host_ready;
    assign bus.host_tag     = alloc_tag;
    assign bus.req_cmd_out  = req_cmd_q;
    assign bus.req_data_out = req_data_q;
    assign bus.req_tag_out  = req_tag_q;
    assign bus.cpl_valid    = cpl_valid_q;
    assign bus.cpl_tag      = cpl_tag_q;
    assign bus.cpl_resp     = cpl_resp_q;
    assign bus.cpl_data     = cpl_data_q;
    assign bus.to_valid     = to_valid_q;
    assign bus.to_tag       = to_tag_q;
    assign bus.err_stray    = err_stray_q;
    assign bus.outstanding  = outstanding_q;
endmodule

// File: tb/tb_calc2_req_port.sv
// tb/tb_calc2_req_port.sv - Self-checking bench for calc2_req_port with directed scenarios and a random reference model
module tb_calc2_req_port;
    localparam int TO = 64;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    calc2_req_port_if bus ();

    calc2_req_port #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, exp finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge c_clk);
        @(negedge c_clk);
    endtask

    task automatic idle_in();
        bus.host_valid  = 1'b0;
        bus.host_cmd    = 4'd0;
        bus.host_op1    = 32'd0;
        bus.host_op2    = 32'd0;
        bus.rsp_resp_in = 2'd0;
        bus.rsp_data_in = 32'd0;
        bus.rsp_tag_in  = 2'd0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
        bus.host_valid = 1'b1;
        bus.host_cmd   = cmd;
        bus.host_op1   = op1;
        bus.host_op2   = op2;
    endtask

    task automatic drive_rsp(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
        bus.rsp_resp_in = resp;
        bus.rsp_data_in = data;
        bus.rsp_tag_in  = tag;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1'b1;
        #1;
        if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h exp 0", bus.host_ready); end checks++;
        if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", bus.outstanding); end checks++;
        if (bus.req_cmd_out !== 4'd0 || bus.cpl_valid !== 1'b0 || bus.to_valid !== 1'b0 || bus.err_stray !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got cmd=%0h cpl=%0h to=%0h stray=%0h exp all 0", bus.req_cmd_out, bus.cpl_valid, bus.to_valid, bus.err_stray);
        end checks++;
        @(negedge c_clk);
        reset = 1'b0;
        #1;
        if (bus.host_ready !== 1'b1 || bus.host_tag !== 2'd0) begin errors++; $display("FAIL reset_release: got ready=%0h tag=%0d exp ready=1 tag=0", bus.host_ready, bus.host_tag); end checks++;
    endtask

    task automatic test_single_add();
        do_reset();
        drive_op(4'd1, 32'h5, 32'h3);
        #1;
        if (bus.host_ready !== 1'b1 || bus.host_tag !== 2'd0) begin errors++; $display("FAIL add_accept: got ready=%0h tag=%0d exp 1/0", bus.host_ready, bus.host_tag); end checks++;
        step();
        bus.host_valid = 1'b0;
        if (bus.req_cmd_out !== 4'd1 || bus.req_data_out !== 32'h5 || bus.req_tag_out !== 2'd0) begin
            errors++; $display("FAIL add_cmd_word: got cmd=%0h data=%0h tag=%0d exp 1/5/0", bus.req_cmd_out, bus.req_data_out, bus.req_tag_out);
        end checks++;
        if (bus.host_ready !== 1'b0 || bus.outstanding !== 3'd1) begin errors++; $display("FAIL add_busy: got ready=%0h out=%0d exp 0/1", bus.host_ready, bus.outstanding); end checks++;
        step();
        if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'h3 || bus.req_tag_out !== 2'd0) begin
            errors++; $display("FAIL add_op2_word: got cmd=%0h data=%0h tag=%0d exp 0/3/0", bus.req_cmd_out, bus.req_data_out, bus.req_tag_out);
        end checks++;
        drive_rsp(2'd1, 32'h8, 2'd0);
        step();
        drive_rsp(2'd0, 32'h0, 2'd0);
        if (bus.cpl_valid !== 1'b1 || bus.cpl_tag !== 2'd0 || bus.cpl_data !== 32'h8 || bus.cpl_resp !== 2'd1) begin
            errors++; $display("FAIL add_cpl: got v=%0h tag=%0d data=%0h resp=%0d exp 1/0/8/1", bus.cpl_valid, bus.cpl_tag, bus.cpl_data, bus.cpl_resp);
        end checks++;
        if (bus.outstanding !== 3'd0 || bus.req_data_out !== 32'd0) begin errors++; $display("FAIL add_drain: got out=%0d data=%0h exp 0/0", bus.outstanding, bus.req_data_out); end checks++;
        step();
        if (bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL add_cpl_pulse: got %0h exp 0", bus.cpl_valid); end checks++;
    endtask

    task automatic test_back_to_back();
        int got;
        do_reset();
        got = 0;
        for (int cy = 0; cy < 20 && got < 4; cy++) begin
            drive_op(4'd2, 32'h100 + cy, 32'h200 + cy);
            #1;
            if (bus.host_ready === 1'b1) begin
                if (bus.host_tag !== 2'(got)) begin errors++; $display("FAIL b2b_tag: got %0d exp %0d", bus.host_tag, got); end checks++;
                got++;
            end
            step();
        end
        if (got !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d exp 4", got); end checks++;
        step();
        #1;
        if (bus.host_ready !== 1'b0 || bus.outstanding !== 3'd4) begin errors++; $display("FAIL b2b_full: got ready=%0h out=%0d exp 0/4", bus.host_ready, bus.outstanding); end checks++;
        drive_rsp(2'd1, 32'hC0FFEE, 2'd2);
        step();
        drive_rsp(2'd0, 32'h0, 2'd0);
        #1;
        if (bus.cpl_valid !== 1'b1 || bus.cpl_tag !== 2'd2) begin errors++; $display("FAIL b2b_cpl: got v=%0h tag=%0d exp 1/2", bus.cpl_valid, bus.cpl_tag); end checks++;
        if (bus.host_ready !== 1'b1 || bus.host_tag !== 2'd2 || bus.outstanding !== 3'd3) begin
            errors++; $display("FAIL b2b_reopen: got ready=%0h tag=%0d out=%0d exp 1/2/3", bus.host_ready, bus.host_tag, bus.outstanding);
        end checks++;
        step();
        bus.host_valid = 1'b0;
        if (bus.req_tag_out !== 2'd2 || bus.req_cmd_out !== 4'd2 || bus.outstanding !== 3'd4) begin
            errors++; $display("FAIL b2b_fifth: got tag=%0d cmd=%0h out=%0d exp 2/2/4", bus.req_tag_out, bus.req_cmd_out, bus.outstanding);
        end checks++;
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        drive_op(4'd1, 32'h11, 32'h22);
        step();
        bus.host_valid = 1'b0;
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            step();
            if (bus.to_valid !== 1'b0) early++;
        end
        if (early !== 0) begin errors++; $display("FAIL to_early: got %0d early pulses exp 0", early); end checks++;
        step();
        if (bus.to_valid !== 1'b1 || bus.to_tag !== 2'd0 || bus.outstanding !== 3'd0) begin
            errors++; $display("FAIL to_fire: got v=%0h tag=%0d out=%0d exp 1/0/0", bus.to_valid, bus.to_tag, bus.outstanding);
        end checks++;
        step();
        if (bus.to_valid !== 1'b0) begin errors++; $display("FAIL to_pulse: got %0h exp 0", bus.to_valid); end checks++;
        drive_rsp(2'd1, 32'h99, 2'd0);
        step();
        drive_rsp(2'd0, 32'h0, 2'd0);
        if (bus.err_stray !== 1'b1 || bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL to_late_rsp: got stray=%0h cpl=%0h exp 1/0", bus.err_stray, bus.cpl_valid); end checks++;
    endtask

    task automatic test_rsp_vs_timeout();
        do_reset();
        drive_op(4'd6, 32'h40, 32'h2);
        step();
        bus.host_valid = 1'b0;
        repeat (TO - 1) step();
        drive_rsp(2'd2, 32'hABCD, 2'd0);
        step();
        drive_rsp(2'd0, 32'h0, 2'd0);
        if (bus.cpl_valid !== 1'b1 || bus.cpl_data !== 32'hABCD || bus.cpl_resp !== 2'd2) begin
            errors++; $display("FAIL race_cpl: got v=%0h data=%0h resp=%0d exp 1/abcd/2", bus.cpl_valid, bus.cpl_data, bus.cpl_resp);
        end checks++;
        if (bus.to_valid !== 1'b0 || bus.outstanding !== 3'd0) begin errors++; $display("FAIL race_no_to: got to=%0h out=%0d exp 0/0", bus.to_valid, bus.outstanding); end checks++;
        step();
        if (bus.to_valid !== 1'b0) begin errors++; $display("FAIL race_no_to_late: got %0h exp 0", bus.to_valid); end checks++;
    endtask

    task automatic test_stray();
        do_reset();
        drive_op(4'd5, 32'h1, 32'h4);
        step();
        bus.host_valid = 1'b0;
        step();
        drive_rsp(2'd3, 32'h7, 2'd1);
        step();
        drive_rsp(2'd0, 32'h0, 2'd0);
        if (bus.err_stray !== 1'b1 || bus.cpl_valid !== 1'b0 || bus.outstanding !== 3'd1) begin
            errors++; $display("FAIL stray: got stray=%0h cpl=%0h out=%0d exp 1/0/1", bus.err_stray, bus.cpl_valid, bus.outstanding);
        end checks++;
    endtask

    task automatic test_cmd_zero_and_reset();
        do_reset();
        drive_op(4'd0, 32'h123, 32'h456);
        #1;
        if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL nop_ready: got %0h exp 1", bus.host_ready); end checks++;
        step();
        bus.host_valid = 1'b0;
        if (bus.req_cmd_out !== 4'd0 || bus.outstanding !== 3'd0 || bus.host_ready !== 1'b1) begin
            errors++; $display("FAIL nop_effect: got cmd=%0h out=%0d ready=%0h exp 0/0/1", bus.req_cmd_out, bus.outstanding, bus.host_ready);
        end checks++;
        drive_op(4'd6, 32'h55, 32'h1);
        step();
        bus.host_valid = 1'b0;
        if (bus.req_cmd_out !== 4'd6) begin errors++; $display("FAIL mid_cmd_setup: got %0h exp 6", bus.req_cmd_out); end checks++;
        #2;
        reset = 1'b1;
        #1;
        if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'd0 || bus.req_tag_out !== 2'd0 || bus.host_ready !== 1'b0 || bus.outstanding !== 3'd0) begin
            errors++; $display("FAIL async_reset: got cmd=%0h data=%0h tag=%0d ready=%0h out=%0d exp all 0", bus.req_cmd_out, bus.req_data_out, bus.req_tag_out, bus.host_ready, bus.outstanding);
        end checks++;
        @(negedge c_clk);
        reset = 1'b0;
        #1;
        if (bus.host_ready !== 1'b1 || bus.host_tag !== 2'd0) begin errors++; $display("FAIL reset_free_mask: got ready=%0h tag=%0d exp 1/0", bus.host_ready, bus.host_tag); end checks++;
        drive_rsp(2'd1, 32'h5, 2'd0);
        step();
        drive_rsp(2'd0, 32'h0, 2'd0);
        if (bus.err_stray !== 1'b1 || bus.cpl_valid !== 1'b0) begin errors++; $display("FAIL abandoned_rsp: got stray=%0h cpl=%0h exp 1/0", bus.err_stray, bus.cpl_valid); end checks++;
    endtask

    task automatic test_random();
        int          born [4];
        int          cyc, nbusy, e_out;
        logic [3:0]  e_cmd;
        logic [31:0] e_data, pend_data, e_cpl_data;
        logic [1:0]  e_tag, e_cpl_tag, e_cpl_resp, e_to_tag, m_tag;
        logic        pend, e_cpl, e_to, e_stray, m_ready, to_done;
        logic        hv;
        logic [3:0]  cmd;
        logic [31:0] op1, op2, rdata;
        logic [1:0]  resp, rtag;
        do_reset();
        for (int t = 0; t < 4; t++) born[t] = -1;
        cyc = 0; e_out = 0; e_cmd = 0; e_data = 0; e_tag = 0; pend = 0; pend_data = 0;
        e_cpl = 0; e_cpl_tag = 0; e_cpl_resp = 0; e_cpl_data = 0; e_to = 0; e_to_tag = 0; e_stray = 0;
        for (int n = 0; n < 1500; n++) begin
            if (bus.req_cmd_out !== e_cmd || bus.req_data_out !== e_data || bus.req_tag_out !== e_tag) begin
                errors++; $display("FAIL rnd_req c%0d: got %0h/%0h/%0d exp %0h/%0h/%0d", cyc, bus.req_cmd_out, bus.req_data_out, bus.req_tag_out, e_cmd, e_data, e_tag);
            end checks++;
            if (bus.cpl_valid !== e_cpl) begin errors++; $display("FAIL rnd_cpl_valid c%0d: got %0h exp %0h", cyc, bus.cpl_valid, e_cpl); end checks++;
            if (e_cpl) begin
                if (bus.cpl_tag !== e_cpl_tag || bus.cpl_resp !== e_cpl_resp || bus.cpl_data !== e_cpl_data) begin
                    errors++; $display("FAIL rnd_cpl c%0d: got %0d/%0d/%0h exp %0d/%0d/%0h", cyc, bus.cpl_tag, bus.cpl_resp, bus.cpl_data, e_cpl_tag, e_cpl_resp, e_cpl_data);
                end checks++;
            end
            if (bus.to_valid !== e_to || (e_to && bus.to_tag !== e_to_tag)) begin
                errors++; $display("FAIL rnd_to c%0d: got %0h/%0d exp %0h/%0d", cyc, bus.to_valid, bus.to_tag, e_to, e_to_tag);
            end checks++;
            if (bus.err_stray !== e_stray) begin errors++; $display("FAIL rnd_stray c%0d: got %0h exp %0h", cyc, bus.err_stray, e_stray); end checks++;
            if (bus.outstanding !== 3'(e_out)) begin errors++; $display("FAIL rnd_outstanding c%0d: got %0d exp %0d", cyc, bus.outstanding, e_out); end checks++;

            nbusy = 0;
            m_tag = 2'd0;
            for (int t = 3; t >= 0; t--) begin
                if (born[t] >= 0) nbusy++;
                else m_tag = 2'(t);
            end
            m_ready = (e_cmd == 4'd0) && (nbusy < 4);

            hv    = 1'($urandom_range(0, 1));
            cmd   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            op1   = $urandom;
            op2   = $urandom;
            resp  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rtag  = 2'($urandom_range(0, 3));
            rdata = $urandom;
            bus.host_valid = hv; bus.host_cmd = cmd; bus.host_op1 = op1; bus.host_op2 = op2;
            drive_rsp(resp, rdata, rtag);
            #1;
            if (bus.host_ready !== m_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0h exp %0h", cyc, bus.host_ready, m_ready); end checks++;
            if (m_ready) begin
                if (bus.host_tag !== m_tag) begin errors++; $display("FAIL rnd_host_tag c%0d: got %0d exp %0d", cyc, bus.host_tag, m_tag); end checks++;
            end

            e_cpl = 0; e_to = 0; e_stray = 0;
            if (resp != 2'd0) begin
                if (born[rtag] >= 0) begin
                    e_cpl = 1; e_cpl_tag = rtag; e_cpl_resp = resp; e_cpl_data = rdata;
                    born[rtag] = -1;
                end else begin
                    e_stray = 1;
                end
            end
            to_done = 0;
            for (int t = 0; t < 4; t++) begin
                if (!to_done && born[t] >= 0 && (cyc - born[t]) >= TO) begin
                    to_done = 1; e_to = 1; e_to_tag = 2'(t); born[t] = -1;
                end
            end
            if (hv && m_ready && cmd != 4'd0) begin
                born[m_tag] = cyc;
                e_cmd = cmd; e_data = op1; e_tag = m_tag;
                pend = 1; pend_data = op2;
            end else if (pend) begin
                e_cmd = 0; e_data = pend_data; e_tag = 0;
                pend = 0;
            end else begin
                e_cmd = 0; e_data = 0; e_tag = 0;
            end
            e_out = 0;
            for (int t = 0; t < 4; t++) if (born[t] >= 0) e_out++;
            cyc++;
            step();
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_timeout();
        test_rsp_vs_timeout();
        test_stray();
        test_cmd_zero_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc2_req_port.md
Name: calc2_req_port

Overview:
- Per-port requester placed directly upstream of one calc2 request port (req<n>_cmd_in/data_in/tag_in). It also consumes the matching out_resp/out_data/out_tag of that port.
- Accepts operations from a host over a valid/ready interface and allocates a free 2-bit tag for each one. Serialises each operation into the calc2 two-cycle request protocol: cmd+operand1, then operand2.
- Tracks up to 4 outstanding tags and matches returning responses to them. Reports completions, timeouts and stray responses.

Parameters:
- TIMEOUT_CYCLES, 64, cycles a tag may stay outstanding before it is forcibly retired (1..2^CNT_W-1).
- CNT_W, 7, width of each per-tag age counter.

Ports:
- c_clk  in  1  functional clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_valid  in  1  host operation valid.
- host_ready  out  1  block can accept an operation this cycle.
- host_cmd  in  [0:3]  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others passed through).
- host_op1  in  [0:31]  operand 1.
- host_op2  in  [0:31]  operand 2.
- host_tag  out  [0:1]  tag assigned to the operation accepted this cycle.
- req_cmd_out  out  [0:3]  to calc2 reqN_cmd_in.
- req_data_out  out  [0:31]  to calc2 reqN_data_in.
- req_tag_out  out  [0:1]  to calc2 reqN_tag_in.
- rsp_resp_in  in  [0:1]  from calc2 out_respN; nonzero = response valid.
- rsp_data_in  in  [0:31]  from calc2 out_dataN.
- rsp_tag_in  in  [0:1]  from calc2 out_tagN.
- cpl_valid  out  1  completion pulse.
- cpl_tag  out  [0:1]  completed tag.
- cpl_resp  out  [0:1]  calc2 response code (1 ok, 2 overflow/underflow, 3 invalid).
- cpl_data  out  [0:31]  result data.
- to_valid  out  1  timeout pulse.
- to_tag  out  [0:1]  timed-out tag.
- err_stray  out  1  pulse: response carried a tag not outstanding.
- outstanding  out  [0:2]  number of tags in flight (0..4).

Behaviour:
- Reset (async, immediate):
  - All outputs 0; host_ready 0 while reset is high.
  - FSM goes to IDLE, free mask = 4'b1111, age counters cleared.
  - Any in-flight issue is abandoned; responses arriving after reset deassertion pulse err_stray.
- Issue FSM has three states, IDLE, CMD and OP2; all req_* outputs are registered.
  - host_ready = (state != CMD) && (free mask != 0).
  - Handshake = host_valid && host_ready. host_tag = lowest-numbered free tag, combinational, valid whenever host_ready.
  - Handshake in IDLE or OP2 with host_cmd != 0: capture op2; the tag becomes busy at this edge; next state CMD.
  - CMD cycle: req_cmd_out = cmd, req_data_out = op1, req_tag_out = tag. Next state OP2.
  - OP2 cycle: req_cmd_out = 0, req_data_out = op2, req_tag_out = 0. Next state IDLE, unless a new handshake occurs.
  - IDLE: req_* all 0.
  - Peak throughput is one operation per 2 cycles; first cmd appears 1 cycle after the handshake.
  - host_cmd == 0: handshake consumed, nothing issued, no tag allocated, state unchanged (OP2 goes to IDLE).
- Response path: when rsp_resp_in != 0, evaluated at each edge.
  - Tag busy: next cycle cpl_valid = 1 with tag, resp and data registered; the tag is freed and its counter cleared at that edge.
  - Tag not busy: next cycle err_stray = 1; no state change.
- Timeout:
  - Each busy tag's counter increments every cycle, saturating at 2^CNT_W-1.
  - When a counter reaches TIMEOUT_CYCLES with no response that cycle: tag freed; next cycle to_valid = 1, to_tag = tag.
  - Response and timeout in the same cycle for the same tag: the response wins; no to_valid.
  - Multiple tags timing out in one cycle: retire the lowest-numbered one; the others retire on subsequent cycles (counters saturate, so none is lost).
  - A late response for a timed-out tag produces err_stray.
- Free-mask rules:
  - A tag freed at edge k is allocatable from cycle k+1 on; same-cycle free-and-allocate is not allowed.
  - outstanding = popcount of busy tags, registered.
  - Full (4 busy) drops host_ready; 0 busy with IDLE is empty.

Test Plan:
- Reset, then a single add (cmd 1, op1 = 0x00000005, op2 = 0x00000003), host_tag = 0.
  - Cycle +1: req_cmd_out = 1, data = 5, tag = 0. Cycle +2: data = 3.
  - Drive rsp_resp_in = 1, data = 8, tag = 0, so cpl_valid = 1, cpl_tag = 0, cpl_data = 8 next cycle, and outstanding returns to 0.
- Five back-to-back valid operations with no responses.
  - Tags 0, 1, 2, 3 are assigned; host_ready drops once outstanding = 4.
  - A response on tag 2 re-enables ready one cycle later, and the 5th operation gets tag 2.
- Issue on tag 0 and return no response.
  - Exactly TIMEOUT_CYCLES (64) cycles after the handshake: to_valid = 1, to_tag = 0.
  - A later response with tag 0 gives err_stray = 1 and no cpl_valid.
- rsp_resp_in = 3, tag = 1, while only tag 0 is busy: err_stray = 1, outstanding unchanged.
- host_cmd = 0 with host_valid: handshake occurs, req_cmd_out stays 0, outstanding stays 0. Then assert reset mid-CMD: all outputs 0 immediately, free mask full.
- Response for tag 0 and timeout of tag 0 in the same cycle (timed to cycle 64): only cpl_valid, no to_valid.
